// File: rtl/rob_commit_queue_pkg.sv
// rob_commit_queue_pkg: shared types and depth default for the commit-side re-order buffer.
package rob_commit_queue_pkg;
    localparam int unsigned XLEN = 32;
    localparam int unsigned ROB_DEPTH = 8;

    typedef enum logic [2:0] {
        FU_NONE, FU_LOAD, FU_STORE, FU_ALU, FU_CTRL, FU_MULT, FU_CSR
    } fu_t;

    typedef struct packed {
        logic            valid;
        logic [5:0]      cause;
        logic [XLEN-1:0] tval;
    } exception_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        fu_t             fu;
        logic [7:0]      op;
        logic [4:0]      rd;
        logic [XLEN-1:0] result;
        logic            valid;
        exception_t      ex;
    } re_order_buffer_entry_t;
endpackage

// File: rtl/rob_commit_queue.sv
// rob_commit_queue: circular re-order buffer collecting writebacks by ID and
// presenting the two oldest entries in program order to the commit stage.
module rob_commit_queue
    import rob_commit_queue_pkg::*;
#(
    parameter int unsigned NR_ENTRIES      = ROB_DEPTH,
    parameter int unsigned NR_WB_PORTS     = 4,
    parameter int unsigned NR_COMMIT_PORTS = 2,
    parameter int unsigned TRANS_ID_BITS   = $clog2(NR_ENTRIES)
) (
    input  logic                                          clk_i,
    input  logic                                          rst_i,
    input  logic                                          flush_i,
    input  logic                                          issue_valid_i,
    input  re_order_buffer_entry_t                        issue_instr_i,
    output logic                                          issue_ready_o,
    output logic [TRANS_ID_BITS-1:0]                      issue_trid_o,
    input  logic [NR_WB_PORTS-1:0]                        wb_valid_i,
    input  logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0]     wb_trid_i,
    input  logic [NR_WB_PORTS-1:0][XLEN-1:0]              wb_result_i,
    input  exception_t [NR_WB_PORTS-1:0]                  wb_ex_i,
    output re_order_buffer_entry_t [NR_COMMIT_PORTS-1:0]  commit_instr_o,
    output logic [NR_COMMIT_PORTS-1:0][TRANS_ID_BITS-1:0] commit_trid_o,
    input  logic [NR_COMMIT_PORTS-1:0]                    commit_ack_i,
    output logic                                          empty_o
);
    localparam int unsigned CW = TRANS_ID_BITS + 1;

    re_order_buffer_entry_t    mem_q [NR_ENTRIES];
    re_order_buffer_entry_t    mem_d [NR_ENTRIES];
    logic [NR_ENTRIES-1:0]     issued_q, issued_d, done_q, done_d;
    logic [TRANS_ID_BITS-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]             count_q, count_d;
    logic                      issue_fire, retire0, retire1;

    assign issue_ready_o = count_q != CW'(NR_ENTRIES);
    assign issue_trid_o  = tail_q;
    assign empty_o       = count_q == '0;
    assign issue_fire    = issue_valid_i && issue_ready_o;
    // a second ack only counts when the head is retiring too
    assign retire0       = commit_ack_i[0] && commit_instr_o[0].valid;
    assign retire1       = retire0 && commit_ack_i[1] && commit_instr_o[1].valid;

    always_comb begin
        for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
            commit_trid_o[k]        = head_q + TRANS_ID_BITS'(k);
            commit_instr_o[k]       = mem_q[head_q + TRANS_ID_BITS'(k)];
            commit_instr_o[k].valid = issued_q[head_q + TRANS_ID_BITS'(k)] && done_q[head_q + TRANS_ID_BITS'(k)];
        end
    end

    always_comb begin
        mem_d    = mem_q;
        issued_d = issued_q;
        done_d   = done_q;
        head_d   = head_q + TRANS_ID_BITS'(retire0) + TRANS_ID_BITS'(retire1);
        tail_d   = tail_q + TRANS_ID_BITS'(issue_fire);
        count_d  = count_q + CW'(issue_fire) - CW'(retire0) - CW'(retire1);
        // ascending loop lets the highest port win on a shared ID
        for (int i = 0; i < NR_WB_PORTS; i++) begin
            if (wb_valid_i[i] && issued_q[wb_trid_i[i]]) begin
                mem_d[wb_trid_i[i]].result = wb_result_i[i];
                mem_d[wb_trid_i[i]].ex     = wb_ex_i[i].valid ? wb_ex_i[i] : mem_q[wb_trid_i[i]].ex;
                done_d[wb_trid_i[i]]       = 1'b1;
            end
        end
        if (retire0) begin
            issued_d[head_q] = 1'b0;
            done_d[head_q]   = 1'b0;
        end
        if (retire1) begin
            issued_d[head_q + 1'b1] = 1'b0;
            done_d[head_q + 1'b1]   = 1'b0;
        end
        if (issue_fire) begin
            mem_d[tail_q]    = issue_instr_i;
            issued_d[tail_q] = 1'b1;
            done_d[tail_q]   = issue_instr_i.ex.valid;
        end
        if (flush_i) begin
            issued_d = '0;
            done_d   = '0;
            head_d   = '0;
            tail_d   = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q    <= '{default: '0};
            issued_q <= '0;
            done_q   <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            issued_q <= issued_d;
            done_q   <= done_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
        end
    end

    ack_head_valid: assert property (@(posedge clk_i) disable iff (rst_i || flush_i)
        commit_ack_i[0] |-> commit_instr_o[0].valid);
    ack_pair_valid: assert property (@(posedge clk_i) disable iff (rst_i || flush_i)
        (commit_ack_i[0] && commit_ack_i[1]) |-> commit_instr_o[1].valid);
endmodule
